// File: rtl/mac_result_collector_if.sv
// Result handshake between the MAC result collector and its downstream consumer.
interface mac_result_collector_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat_flag;

    modport master (output out_valid, output out_data, output sat_flag, input out_ready);
    modport slave  (input out_valid, input out_data, input sat_flag, output out_ready);
endinterface

// File: rtl/mac_result_collector.sv
// Counts operand pairs of one dot-product job, waits for the MAC pipeline to drain,
// then holds the captured accumulator on a valid/ready handshake with status flags.
module mac_result_collector #(
    parameter int unsigned N_PAIRS      = 10,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [15:0]                   mac_result,
    mac_result_collector_if.master        res_if,
    output logic                          err_flag,
    output logic                          busy,
    output logic [7:0]                    job_cnt
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DRN_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DRAIN, S_HOLD} state_t;

    state_t              r_state,     w_state_nxt;
    logic [CNT_W-1:0]    r_pair_cnt,  w_pair_cnt_nxt;
    logic [DRN_W-1:0]    r_drain_cnt, w_drain_cnt_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
    logic                r_sat,       w_sat_nxt;
    logic                r_err,       w_err_nxt;
    logic                r_busy,      w_busy_nxt;
    logic [CNT_W-1:0]    r_job_cnt,   w_job_cnt_nxt;

    logic w_last_pair;
    logic w_drain_done;
    logic w_xfer;
    logic w_sat_c;

    assign w_last_pair  = in_valid && (r_pair_cnt == CNT_W'(N_PAIRS - 1));
    assign w_drain_done = (r_drain_cnt == DRN_W'(DRAIN_CYCLES));
    assign w_xfer       = r_out_valid && res_if.out_ready;
    assign w_sat_c      = (mac_result == 16'h7FFF) || (mac_result == 16'h8001);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)        w_state_nxt = S_COUNT;
            S_COUNT: if (w_last_pair)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_xfer)       w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; in_valid outside COUNT only matters once a job is open
    always_comb begin
        w_pair_cnt_nxt  = r_pair_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_sat_nxt       = r_sat;
        w_err_nxt       = r_err;
        w_job_cnt_nxt   = r_job_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pair_cnt_nxt = '0;
                    w_err_nxt      = 1'b0;
                end
            end
            S_COUNT: begin
                if (in_valid) begin
                    w_pair_cnt_nxt = r_pair_cnt + CNT_W'(1);
                    if (w_last_pair) w_drain_cnt_nxt = DRN_W'(1);
                end
            end
            S_DRAIN: begin
                if (in_valid) w_err_nxt = 1'b1;
                if (w_drain_done) begin
                    w_out_data_nxt  = mac_result;
                    w_sat_nxt       = w_sat_c;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DRN_W'(1);
                end
            end
            S_HOLD: begin
                if (in_valid) w_err_nxt = 1'b1;
                if (w_xfer) begin
                    w_out_valid_nxt = 1'b0;
                    w_job_cnt_nxt   = r_job_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pair_cnt  <= '0;
            r_drain_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_job_cnt   <= '0;
        end else begin
            r_pair_cnt  <= w_pair_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_sat       <= w_sat_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_job_cnt   <= w_job_cnt_nxt;
        end
    end

    assign res_if.out_valid = r_out_valid;
    assign res_if.out_data  = r_out_data;
    assign res_if.sat_flag  = r_sat;
    assign err_flag         = r_err;
    assign busy             = r_busy;
    assign job_cnt          = r_job_cnt;

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: a scoreboard queue holds expected captures,
// a monitor pops and compares on every handshake transfer.
module tb_mac_result_collector;

    localparam int unsigned N_PAIRS      = 10;
    localparam int unsigned DRAIN_CYCLES = 5;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        start      = 1'b0;
    logic        in_valid   = 1'b0;
    logic [15:0] mac_result = 16'h0;
    logic        err_flag;
    logic        busy;
    logic [7:0]  job_cnt;

    mac_result_collector_if res_if();

    mac_result_collector #(
        .N_PAIRS      (N_PAIRS),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .mac_result (mac_result),
        .res_if     (res_if),
        .err_flag   (err_flag),
        .busy       (busy),
        .job_cnt    (job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_jobs = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && res_if.out_valid && res_if.out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got transfer data %0h expected none", res_if.out_data);
                end else begin
                    e = sb_q.pop_front();
                    if (res_if.out_data !== e.data || res_if.sat_flag !== e.sat) begin
                        n_fail++;
                        $display("FAIL sb_result: got data %0h sat %0b expected data %0h sat %0b",
                                 res_if.out_data, res_if.sat_flag, e.data, e.sat);
                    end
                end
            end
        end
    end

    // mac_result sampled at the k-th edge after the final pair is base+k
    task automatic run_job(input int gap, input logic [15:0] base, input int hold,
                           input bit inj_err, input bit start_noise);
        exp_t        e;
        logic [15:0] capv;
        capv   = base + 16'(DRAIN_CYCLES);
        e.data = capv;
        e.sat  = (capv == 16'h7FFF) || (capv == 16'h8001);
        sb_q.push_back(e);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared", 32'(err_flag), 32'd0);

        for (int i = 0; i < int'(N_PAIRS); i++) begin
            in_valid = 1'b1;
            if (start_noise && i == 3) start = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            if (i != int'(N_PAIRS) - 1) repeat (gap) @(negedge clk);
        end

        for (int k = 1; k <= int'(DRAIN_CYCLES); k++) begin
            mac_result = base + 16'(k);
            if (inj_err && k == 2) in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk("valid_timing", 32'(res_if.out_valid), (k == int'(DRAIN_CYCLES)) ? 32'd1 : 32'd0);
        end
        chk("cap_data", 32'(res_if.out_data), 32'(capv));
        if (inj_err) chk("err_set", 32'(err_flag), 32'd1);

        for (int h = 0; h < hold; h++) begin
            mac_result = base + 16'(int'(DRAIN_CYCLES) + 1 + h);
            if (start_noise) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("hold_valid", 32'(res_if.out_valid), 32'd1);
            chk("hold_data", 32'(res_if.out_data), 32'(capv));
            chk("hold_busy", 32'(busy), 32'd1);
        end

        res_if.out_ready = 1'b1;
        mac_result       = ~base;
        if (start_noise) start = 1'b1;
        @(negedge clk);
        res_if.out_ready = 1'b0;
        start            = 1'b0;
        exp_jobs         = exp_jobs + 8'd1;
        chk("valid_drop", 32'(res_if.out_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("job_cnt", 32'(job_cnt), 32'(exp_jobs));
        chk("err_after", 32'(err_flag), 32'(inj_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(res_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(res_if.out_data), 32'd0);
        chk("rst_sat", 32'(res_if.sat_flag), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_job_cnt", 32'(job_cnt), 32'd0);
        rst = 1'b1;

        // in_valid while IDLE is not an error
        @(negedge clk); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("idle_in_valid_err", 32'(err_flag), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        run_job(0, 16'h0000, 0, 1'b0, 1'b0);  // basic
        run_job(1, 16'h0000, 0, 1'b0, 1'b0);  // gapped
        run_job(0, 16'h1230, 7, 1'b0, 1'b0);  // backpressure
        run_job(0, 16'h7FFC, 0, 1'b0, 1'b0);  // captures 8001
        run_job(0, 16'h7FFA, 0, 1'b0, 1'b0);  // captures 7FFF
        run_job(0, 16'h0040, 2, 1'b1, 1'b0);  // error inject
        run_job(0, 16'h0050, 0, 1'b0, 1'b0);  // error cleared by start

        // Reset two edges after the final pair, with an error already flagged
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < int'(N_PAIRS); i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_err", 32'(err_flag), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(res_if.out_valid), 32'd0);
        chk("arst_out_data", 32'(res_if.out_data), 32'd0);
        chk("arst_sat", 32'(res_if.sat_flag), 32'd0);
        chk("arst_err", 32'(err_flag), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_job_cnt", 32'(job_cnt), 32'd0);
        @(negedge clk); rst = 1'b1;
        exp_jobs = 8'd0;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 32'(res_if.out_valid), 32'd0);
        run_job(0, 16'h0100, 0, 1'b0, 1'b0);

        // 255 more jobs wrap the counter; some carry stray starts in COUNT and HOLD
        for (int j = 0; j < 255; j++) begin
            run_job((j % 5 == 0) ? 1 : 0, 16'(j * 3), (j % 4 == 0) ? 1 : 0, 1'b0, (j % 8 == 0));
        end
        chk("job_cnt_wrap", 32'(job_cnt), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
